blake_stream_host: RTL and testbench

BLAKE_STREAM_HOST -- requirements
Module: blake_stream_host

---
 rtl/blake_stream_host.sv | 124 ++++++++++++
 tb/tb_blake_stream_host.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blake_stream_host.sv
// Streaming wrapper around a BLAKE hash core: gathers ten 64-bit header words
// into a 640-bit block, starts the core, waits for its digest (with timeout),
// then streams the 512-bit digest out as eight 64-bit words.
module blake_stream_host #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic [63:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [639:0] core_din,
    output logic         core_ena,
    input  logic         core_rdy,
    input  logic [511:0] core_dout,
    output logic [63:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         busy,
    output logic         err,
    input  logic         err_clr
);
    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

    localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];

    state_t       state, state_nxt;
    logic [3:0]   wcnt;
    logic [2:0]   j;
    logic [7:0]   timer;
    logic [511:0] digest;
    logic         s_fire, m_fire, capture, timeout;
    logic [9:0]   din_lo;
    logic [8:0]   dig_lo;

    assign s_fire  = s_valid && s_ready;
    assign m_fire  = m_valid && m_ready;
    assign capture = (state == WAIT) && core_rdy;
    // core_rdy on the final timer value still wins over the timeout
    assign timeout = (state == WAIT) && !core_rdy && (timer == TMO);
    // word 0 lands in the top 64 bits, word 9 in the bottom
    assign din_lo  = 10'd576 - {wcnt, 6'd0};
    assign dig_lo  = {~j, 6'd0};
    assign busy    = !((state == LOAD) && (wcnt == 4'd0));

    // next-state and handshake outputs; s_ready is held low while in reset
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        core_ena  = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = '0;
        case (state)
            LOAD: begin
                s_ready = !rstb;
                if (s_valid && !rstb && (wcnt == 4'd9))
                    state_nxt = START;
            end
            START: begin
                core_ena  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (core_rdy)
                    state_nxt = DRAIN;
                else if (timer == TMO)
                    state_nxt = LOAD;
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_data  = digest[dig_lo +: 64];
                m_last  = (j == 3'd7);
                if (m_ready && (j == 3'd7))
                    state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) state <= LOAD;
        else      state <= state_nxt;
    end

    // header assembly; core_din only changes on accepted words, so it is
    // stable from START until the next block begins loading
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            wcnt     <= 4'd0;
            core_din <= '0;
        end else if (s_fire) begin
            core_din[din_lo +: 64] <= s_data;
            wcnt <= (wcnt == 4'd9) ? 4'd0 : wcnt + 4'd1;
        end
    end

    // WAIT timer and digest capture
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            timer  <= 8'd0;
            digest <= '0;
        end else begin
            if ((state == WAIT) && !capture && !timeout) timer <= timer + 8'd1;
            else                                         timer <= 8'd0;
            if (capture) digest <= core_dout;
        end
    end

    // digest word index; wraps back to 0 after the last word
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)        j <= 3'd0;
        else if (m_fire) j <= j + 3'd1;
    end

    // sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)         err <= 1'b0;
        else if (timeout) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end
endmodule

// File: tb/tb_blake_stream_host.sv
// Self-checking bench for blake_stream_host: table of block scenarios plus
// hand-written reset sequences, checked against a transaction-level model.
module tb_blake_stream_host;
    localparam int TMO = 60;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic [63:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [639:0] core_din;
    logic         core_ena;
    logic         core_rdy = 1'b0;
    logic [511:0] core_dout = '0;
    logic [63:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         m_last;
    logic         busy;
    logic         err;
    logic         err_clr = 1'b0;

    blake_stream_host #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstb(rstb), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .core_din(core_din), .core_ena(core_ena), .core_rdy(core_rdy), .core_dout(core_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rnd;          // random header words (else 0..9)
        int rdy_delay;    // WAIT cycle index of core_rdy, -1 = never
        bit gaps;         // random idle cycles on s_valid
        int mr_mode;      // 0 = m_ready high, 1 = toggle from 0, 2 = random
        bit rdy_in_load;  // stray core_rdy pulse while loading
        bit clr_in_wait;  // hold err_clr high through WAIT
        bit exp_tmo;      // expected: block ends in timeout
    } vec_t;

    vec_t         tbl[7];
    int           checks = 0;
    int           errors = 0;
    logic [639:0] exp_din;
    logic [511:0] exp_dig;
    logic         exp_err = 1'b0;

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle bound expired", name);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_core_ena"}, core_ena, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_core_din"}, core_din, 0);
    endtask

    // Feed n header words; the model shifts each accepted word into exp_din.
    task automatic load_words(input int n, input bit rnd, input logic [63:0] base,
                              input bit gaps, input bit rdy_in_load);
        logic [63:0] w;
        int k = 0;
        int g = 0;
        bit go;
        exp_din = '0;
        w = rnd ? {$urandom, $urandom} : base;
        while (k < n && g < 400) begin
            chk("s_ready_load", s_ready, 1);
            chk("core_ena_load", core_ena, 0);
            chk("m_valid_load", m_valid, 0);
            chk("busy_load", busy, (k != 0));
            go = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_valid   = go;
            s_data    = go ? w : {$urandom, $urandom};
            core_rdy  = rdy_in_load && (g == 2);
            core_dout = rand512();
            tick();
            core_rdy = 1'b0;
            if (go) begin
                exp_din = {exp_din[575:0], w};
                k++;
                w = rnd ? {$urandom, $urandom} : base + 64'(k);
            end
            g++;
        end
        s_valid = 1'b0;
        if (k < n) bound_fail("load_bound");
        if (n == 10) begin
            chk("core_ena_start", core_ena, 1);
            chk("s_ready_start", s_ready, 0);
            chk("busy_start", busy, 1);
            chk("core_din_start", core_din, exp_din);
            chk("m_valid_start", m_valid, 0);
        end
    endtask

    // Called in START; waits d WAIT cycles then pulses core_rdy (d<0: never).
    task automatic wait_phase(input int d, input logic [511:0] dout, input bit clr, input bit exp_tmo);
        tick();
        err_clr = clr;
        for (int i = 0; i <= TMO; i++) begin
            chk("core_ena_wait", core_ena, 0);
            chk("m_valid_wait", m_valid, 0);
            chk("s_ready_wait", s_ready, 0);
            chk("err_wait", err, exp_err);
            core_rdy  = (i == d);
            core_dout = (i == d) ? dout : rand512();
            tick();
            core_rdy = 1'b0;
            if (i == d) break;
        end
        err_clr = 1'b0;
        if (exp_tmo) begin
            exp_err = 1'b1;
            chk("err_timeout", err, 1);
            chk("s_ready_after_tmo", s_ready, 1);
            chk("m_valid_after_tmo", m_valid, 0);
            chk("busy_after_tmo", busy, 0);
        end else begin
            exp_dig = dout;
            chk("m_valid_first", m_valid, 1);
            chk("err_capture", err, exp_err);
            chk("core_din_hold", core_din, exp_din);
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_err = 1'b0;
        chk("err_clr", err, 0);
    endtask

    // Accept stop_after digest words; expected word j is exp_dig from the MSW down.
    task automatic drain(input int mode, input int stop_after);
        int got = 0;
        int g = 0;
        bit mr;
        while (got < stop_after && g < 100) begin
            chk("m_valid_drain", m_valid, 1);
            chk("m_data", m_data, exp_dig[511-64*got -: 64]);
            chk("m_last", m_last, (got == 7));
            mr = (mode == 0) ? 1'b1 : (mode == 1) ? g[0] : 1'($urandom_range(0, 1));
            m_ready = mr;
            tick();
            if (mr) got++;
            g++;
        end
        m_ready = 1'b0;
        if (got < stop_after) bound_fail("drain_bound");
        if (stop_after == 8) begin
            chk("m_valid_done", m_valid, 0);
            chk("m_last_done", m_last, 0);
            chk("s_ready_done", s_ready, 1);
            chk("busy_done", busy, 0);
        end
    endtask

    task automatic pulse_reset(input string tag);
        #2 rstb = 1'b1;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        rstb    = 1'b0;
        exp_err = 1'b0;
        tick();
        chk({tag, "_s_ready_release"}, s_ready, 1);
    endtask

    initial begin
        logic [511:0] dout;

        tbl[0] = '{0, 20,      0, 0, 0, 0, 0};
        tbl[1] = '{1, 3,       1, 1, 1, 0, 0};
        tbl[2] = '{1, 0,       1, 2, 0, 0, 0};
        tbl[3] = '{1, -1,      0, 0, 0, 0, 1};
        tbl[4] = '{1, TMO,     1, 2, 1, 0, 0};
        tbl[5] = '{1, -1,      1, 0, 0, 1, 1};
        tbl[6] = '{1, TMO - 1, 0, 1, 0, 0, 0};

        #1 rstb = 1'b1;
        #2 check_reset_outputs("por");
        @(negedge clk);
        rstb = 1'b0;
        tick();
        chk("s_ready_after_por", s_ready, 1);

        for (int v = 0; v < 7; v++) begin
            if (v == 0) for (int i = 0; i < 8; i++) dout[511-64*i -: 64] = 64'hA0 + 64'(i);
            else        dout = rand512();
            load_words(10, tbl[v].rnd, 64'h0, tbl[v].gaps, tbl[v].rdy_in_load);
            wait_phase(tbl[v].rdy_delay, dout, tbl[v].clr_in_wait, tbl[v].exp_tmo);
            if (tbl[v].exp_tmo) clear_err();
            else                drain(tbl[v].mr_mode, 8);
        end

        // reset after six header words: partial header must be forgotten
        load_words(6, 0, 64'h100, 0, 0);
        pulse_reset("rst_load");
        load_words(10, 0, 64'h200, 1, 0);
        wait_phase(5, rand512(), 0, 0);
        drain(0, 8);

        // reset in the middle of DRAIN, with err left set beforehand
        load_words(10, 1, 64'h0, 0, 0);
        wait_phase(-1, rand512(), 0, 1);
        load_words(10, 1, 64'h0, 0, 0);
        wait_phase(2, rand512(), 0, 0);
        drain(2, 3);
        pulse_reset("rst_drain");
        load_words(10, 1, 64'h0, 1, 0);
        wait_phase(7, rand512(), 0, 0);
        drain(1, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
